// File: rtl/phy_tx_pkg.sv
// -----------------------------------------------------------------------------
// phy_tx_pkg
// Shared definitions for the PHY TX lane striper:
//   IDLE_SYM_DEF  default idle symbol driven on every lane with no data in flight
//   tx_state_t    striper FSM state
//   calc_beats    number of beats a word is split into
//   lane_lsb      bit offset of a lane symbol inside a beat / data_out
// -----------------------------------------------------------------------------
package phy_tx_pkg;

    localparam logic [7:0] IDLE_SYM_DEF = 8'hBC;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // Beats per word; returns 0 for a degenerate lane geometry so the
    // width check in the top fails loudly instead of dividing by zero.
    function automatic int calc_beats(input int word_w, input int lanes, input int lane_w);
        int beat_w;
        beat_w = lanes * lane_w;
        if (beat_w <= 0) begin
            return 0;
        end
        return word_w / beat_w;
    endfunction

    // Lane 0 carries the most significant symbol of a beat, so a beat lands
    // on data_out unchanged: lane l sits lanes-1-l symbols above bit 0.
    function automatic int lane_lsb(input int lane, input int lanes, input int lane_w);
        return (lanes - 1 - lane) * lane_w;
    endfunction

endpackage

// File: rtl/phy_tx_fifo.sv
// -----------------------------------------------------------------------------
// phy_tx_fifo
// Synchronous FIFO with occupancy count. Head word is presented on dout
// without a read latency so the consumer can load it on the popping edge.
// Ports:
//   clk_f   clock
//   reset   asynchronous active-low reset, empties the FIFO
//   push    write din (ignored when full)
//   din     write data
//   pop     advance the head (ignored when empty)
//   dout    head word
//   full    level == DEPTH
//   empty   level == 0
//   level   occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module phy_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_f,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign dout  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through level.
    always_ff @(posedge clk_f) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/phy_tx_lane_striper.sv
// -----------------------------------------------------------------------------
// phy_tx_lane_striper
// Buffers WORD_W-bit words in a DEPTH-entry FIFO and stripes each one across
// LANES lanes as BEATS consecutive beats, most significant beat first. Lanes
// carry IDLE_SYM whenever no word is in flight. All outputs are registered.
// Ports:
//   clk_f       clock, all state on the rising edge
//   reset       asynchronous active-low reset
//   active      link enable; low stops new words from starting
//   in_valid    input word valid
//   in_ready    FIFO can accept (never raised by a same-cycle pop)
//   data_in     input word
//   data_out    current beat; lane 0 is the most significant symbol
//   valid_out   per-lane valid, all bits equal
//   fifo_level  FIFO occupancy 0..DEPTH
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | lanes idle; loads the FIFO head when active and data waiting
// SEND  | drives beat beat_cnt; on the last beat chains the next word
// -----------------------------------------------------------------------------
module phy_tx_lane_striper
    import phy_tx_pkg::*;
#(
    parameter int                WORD_W   = 32,
    parameter int                LANES    = 2,
    parameter int                LANE_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [LANE_W-1:0] IDLE_SYM = LANE_W'(IDLE_SYM_DEF)
) (
    input  logic                      clk_f,
    input  logic                      reset,
    input  logic                      active,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W-1:0]         data_in,
    output logic [LANES*LANE_W-1:0]   data_out,
    output logic [LANES-1:0]          valid_out,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int BEAT_W = LANES * LANE_W;
    localparam int BEATS  = calc_beats(WORD_W, LANES, LANE_W);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    generate
        if (BEATS < 1 || WORD_W != BEATS * BEAT_W) begin : g_bad_width
            $error("phy_tx_lane_striper: WORD_W must be a whole multiple of LANES*LANE_W");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("phy_tx_lane_striper: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    tx_state_t          state;
    logic [WORD_W-1:0]  shift_reg;
    logic [CNT_W-1:0]   beat_cnt;
    logic               rst_done;
    logic               fifo_full;
    logic               fifo_empty;
    logic [WORD_W-1:0]  fifo_head;
    logic               push;
    logic               pop;
    logic               last_beat;
    logic [BEAT_W-1:0]  lane_beat;

    // rst_done keeps in_ready low until the first edge after reset release.
    assign in_ready  = rst_done && !fifo_full;
    assign push      = in_valid && in_ready;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign pop       = active && !fifo_empty &&
                       ((state == IDLE) || ((state == SEND) && last_beat));

    phy_tx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_f (clk_f),
        .reset (reset),
        .push  (push),
        .din   (data_in),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // The shift register always holds the current beat in its top BEAT_W
    // bits; split it into lane symbols in lane order.
    always_comb begin
        lane_beat = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_beat[lane_lsb(l, LANES, LANE_W) +: LANE_W] =
                shift_reg[WORD_W - 1 - l * LANE_W -: LANE_W];
        end
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            beat_cnt  <= '0;
            rst_done  <= 1'b0;
            data_out  <= {LANES{IDLE_SYM}};
            valid_out <= '0;
        end else begin
            rst_done <= 1'b1;
            case (state)
                IDLE: begin
                    data_out  <= {LANES{IDLE_SYM}};
                    valid_out <= '0;
                    if (pop) begin
                        shift_reg <= fifo_head;
                        beat_cnt  <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    data_out  <= lane_beat;
                    valid_out <= '1;
                    if (last_beat) begin
                        beat_cnt <= '0;
                        // Chaining on the last beat avoids an idle bubble
                        // between back-to-back words.
                        if (pop) begin
                            shift_reg <= fifo_head;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        beat_cnt  <= beat_cnt + 1'b1;
                        shift_reg <= shift_reg << BEAT_W;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_tx_lane_striper.sv
module tb_phy_tx_lane_striper;

    localparam int DEPTH = 4;

    logic        clk_f    = 1'b0;
    logic        reset    = 1'b1;
    logic        active   = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] data_in  = '0;

    // two-lane (2 beats per word) instance
    logic        rdy2;
    logic [15:0] dout2;
    logic [1:0]  vout2;
    logic [2:0]  lvl2;
    // four-lane (1 beat per word) instance
    logic        rdy4;
    logic [31:0] dout4;
    logic [3:0]  vout4;
    logic [2:0]  lvl4;

    phy_tx_lane_striper #(.WORD_W(32), .LANES(2), .LANE_W(8), .DEPTH(DEPTH)) dut2 (
        .clk_f(clk_f), .reset(reset), .active(active), .in_valid(in_valid),
        .in_ready(rdy2), .data_in(data_in), .data_out(dout2), .valid_out(vout2),
        .fifo_level(lvl2)
    );

    phy_tx_lane_striper #(.WORD_W(32), .LANES(4), .LANE_W(8), .DEPTH(DEPTH)) dut4 (
        .clk_f(clk_f), .reset(reset), .active(active), .in_valid(in_valid),
        .in_ready(rdy4), .data_in(data_in), .data_out(dout4), .valid_out(vout4),
        .fifo_level(lvl4)
    );

    always #5 clk_f = ~clk_f;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Index 0 = two-lane instance, index 1 = four-lane instance.
    // Each keeps a list of queued words, the word in flight and how many of
    // its beats remain; a beat is the slice of the word taken MSB first.
    int          m_lvl  [2];
    logic [31:0] m_q    [2][DEPTH];
    logic [31:0] m_cur  [2];
    int          m_left [2];
    logic [31:0] m_data [2];
    logic [3:0]  m_valid[2];
    bit          m_rel;

    function automatic int m_beats(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic logic [31:0] m_idle(input int k);
        return (k == 0) ? 32'h0000BCBC : 32'hBCBCBCBC;
    endfunction

    always @(posedge clk_f or negedge reset) begin : model
        bit acc;
        bit take;
        int bw;
        if (!reset) begin
            m_rel = 0;
            for (int k = 0; k < 2; k++) begin
                m_lvl[k]   = 0;
                m_left[k]  = 0;
                m_cur[k]   = '0;
                m_data[k]  = m_idle(k);
                m_valid[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bw   = 32 / m_beats(k);
                acc  = in_valid && m_rel && (m_lvl[k] < DEPTH);
                take = active && (m_lvl[k] > 0) && (m_left[k] <= 1);
                if (m_left[k] > 0) begin
                    m_data[k] = m_cur[k] >> ((m_left[k] - 1) * bw);
                    if (bw == 16) m_data[k][31:16] = '0;
                    m_valid[k] = (k == 0) ? 4'h3 : 4'hF;
                    m_left[k]--;
                end else begin
                    m_data[k]  = m_idle(k);
                    m_valid[k] = '0;
                end
                if (take) begin
                    m_cur[k] = m_q[k][0];
                    for (int i = 0; i < DEPTH - 1; i++) m_q[k][i] = m_q[k][i+1];
                    m_lvl[k]--;
                    m_left[k] = m_beats(k);
                end
                if (acc) begin
                    m_q[k][m_lvl[k]] = data_in;
                    m_lvl[k]++;
                end
            end
            m_rel = 1;
        end
    end

    // ---------------- per-cycle compare + beat capture ----------------
    logic [31:0] cap2[$];
    int          capc2[$];
    logic [31:0] cap4[$];
    int          capc4[$];
    logic [3:0]  capv4[$];

    always @(negedge clk_f) begin
        if (chk_en) begin
            check("cmp_rdy2",  rdy2,  m_rel && (m_lvl[0] < DEPTH));
            check("cmp_dout2", dout2, m_data[0]);
            check("cmp_vout2", vout2, m_valid[0]);
            check("cmp_lvl2",  lvl2,  m_lvl[0]);
            check("cmp_rdy4",  rdy4,  m_rel && (m_lvl[1] < DEPTH));
            check("cmp_dout4", dout4, m_data[1]);
            check("cmp_vout4", vout4, m_valid[1]);
            check("cmp_lvl4",  lvl4,  m_lvl[1]);
            cyc++;
            if (vout2 != '0) begin
                cap2.push_back({16'h0, dout2});
                capc2.push_back(cyc);
            end
            if (vout4 != '0) begin
                cap4.push_back(dout4);
                capc4.push_back(cyc);
                capv4.push_back(vout4);
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic [31:0] exp2[$];
    logic [31:0] exp4[$];

    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        in_valid = 1'b1;
        data_in  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clear_caps();
        cap2.delete(); capc2.delete();
        cap4.delete(); capc4.delete(); capv4.delete();
    endtask

    // Captured beats must equal the literal list and arrive on consecutive cycles.
    task automatic check_caps(input string nm);
        check({nm, "_count2"}, cap2.size(), exp2.size());
        for (int i = 0; i < exp2.size() && i < cap2.size(); i++) begin
            check({nm, "_beat2"}, cap2[i], exp2[i]);
            if (i > 0) check({nm, "_gap2"}, capc2[i] - capc2[i-1], 1);
        end
        check({nm, "_count4"}, cap4.size(), exp4.size());
        for (int i = 0; i < exp4.size() && i < cap4.size(); i++) begin
            check({nm, "_beat4"}, cap4[i], exp4[i]);
            check({nm, "_valid4"}, capv4[i], 4'hF);
            if (i > 0) check({nm, "_gap4"}, capc4[i] - capc4[i-1], 1);
        end
    endtask

    initial begin
        // 1. reset state and release
        #1 reset = 1'b0;
        #1 chk_en = 1;
        check("rst_dout2", dout2, 16'hBCBC);
        check("rst_vout2", vout2, 2'b00);
        check("rst_rdy2",  rdy2,  1'b0);
        check("rst_dout4", dout4, 32'hBCBCBCBC);
        check("rst_vout4", vout4, 4'h0);
        tick(); tick();
        reset = 1'b1;
        tick(); tick();
        check("rel_rdy2", rdy2, 1'b1);
        check("rel_lvl2", lvl2, 3'd0);

        // 2. single word, latency and return to idle
        active = 1'b1;
        push(32'hFFFFEEEE);
        tick();
        check("s2_not_yet", vout2, 2'b00);
        tick();
        check("s2_b0_2",  dout2, 16'hFFFF);
        check("s2_v0_2",  vout2, 2'b11);
        check("s2_w_4",   dout4, 32'hFFFFEEEE);
        check("s2_v_4",   vout4, 4'hF);
        tick();
        check("s2_b1_2",  dout2, 16'hEEEE);
        check("s2_v1_2",  vout2, 2'b11);
        check("s2_idle4", vout4, 4'h0);
        tick();
        check("s2_idle_d2", dout2, 16'hBCBC);
        check("s2_idle_v2", vout2, 2'b00);
        repeat (2) tick();

        // 3. back-to-back words, no bubble
        clear_caps();
        push(32'h12345678);
        push(32'hAAAA1234);
        push(32'hBBBBAAAA);
        repeat (10) tick();
        exp2 = '{32'h1234, 32'h5678, 32'hAAAA, 32'h1234, 32'hBBBB, 32'hAAAA};
        exp4 = '{32'h12345678, 32'hAAAA1234, 32'hBBBBAAAA};
        check_caps("s3");

        // 4. fill while inactive, 5th word held until the first pop
        active = 1'b0;
        clear_caps();
        push(32'h01020304);
        push(32'h05060708);
        push(32'h090A0B0C);
        push(32'h0D0E0F10);
        check("s4_full_lvl2", lvl2, 3'd4);
        check("s4_full_rdy2", rdy2, 1'b0);
        check("s4_full_lvl4", lvl4, 3'd4);
        in_valid = 1'b1;
        data_in  = 32'h11121314;
        tick();
        check("s4_held_lvl2", lvl2, 3'd4);
        check("s4_held_rdy2", rdy2, 1'b0);
        active = 1'b1;
        tick();
        check("s4_pop_lvl2", lvl2, 3'd3);
        check("s4_pop_rdy2", rdy2, 1'b1);
        tick();
        in_valid = 1'b0;
        check("s4_acc_lvl2", lvl2, 3'd4);
        repeat (14) tick();
        exp2 = '{32'h0102, 32'h0304, 32'h0506, 32'h0708, 32'h090A,
                 32'h0B0C, 32'h0D0E, 32'h0F10, 32'h1112, 32'h1314};
        exp4 = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314};
        check_caps("s4");

        // 5a. active drops during beat 0: word completes, rest held
        active = 1'b0;
        push(32'hCCEEEEEE);
        push(32'h99998888);
        tick();
        check("s5_lvl2", lvl2, 3'd2);
        active = 1'b1;
        tick();
        tick();
        check("s5_b0_2", dout2, 16'hCCEE);
        active = 1'b0;
        tick();
        check("s5_b1_2", dout2, 16'hEEEE);
        check("s5_v1_2", vout2, 2'b11);
        tick();
        check("s5_idle_d2", dout2, 16'hBCBC);
        check("s5_idle_v2", vout2, 2'b00);
        check("s5_kept_lvl2", lvl2, 3'd1);
        tick();
        check("s5_still_lvl2", lvl2, 3'd1);

        // 5b. reset during beat 0 with a word still queued
        active   = 1'b1;
        in_valid = 1'b1;
        data_in  = 32'h77776666;
        tick();
        in_valid = 1'b0;
        tick();
        check("s5r_b0_2", dout2, 16'h9999);
        reset = 1'b0;
        #1;
        check("s5r_dout2", dout2, 16'hBCBC);
        check("s5r_vout2", vout2, 2'b00);
        check("s5r_lvl2",  lvl2,  3'd0);
        check("s5r_rdy2",  rdy2,  1'b0);
        check("s5r_dout4", dout4, 32'hBCBCBCBC);
        check("s5r_lvl4",  lvl4,  3'd0);
        tick(); tick();
        reset = 1'b1;
        tick(); tick();

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) active = ~active;
            in_valid = ($urandom_range(0, 3) != 0);
            data_in  = $urandom();
            if (c == 1500) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        active   = 1'b1;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
